// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry, address-math width and controller state encoding.
package vga_pkg;
  localparam int H_RES    = 800;
  localparam int V_RES    = 480;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int ADDR_W   = 19;
  // Wide enough for 2047*H_RES+2047 so out-of-range coordinates never wrap into range.
  localparam int CALC_W   = 22;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fb_state_e;
endpackage

// File: rtl/vga_addr_calc.sv
// Combinational (x,y) -> linear frame-buffer address with range check.
// Shared by the write path here and by the scan-out read side.
module vga_addr_calc #(
  parameter int H_RES  = vga_pkg::H_RES,
  parameter int V_RES  = vga_pkg::V_RES,
  parameter int ADDR_W = vga_pkg::ADDR_W
) (
  input  logic [10:0]       x,
  input  logic [10:0]       y,
  output logic              in_range,
  output logic [ADDR_W-1:0] addr
);
  import vga_pkg::*;

  localparam logic [CALC_W-1:0] H_W = CALC_W'(H_RES);
  localparam logic [CALC_W-1:0] V_W = CALC_W'(V_RES);

  logic [CALC_W-1:0] lin;

  assign lin      = CALC_W'(y) * H_W + CALC_W'(x);
  assign in_range = (CALC_W'(x) < H_W) && (CALC_W'(y) < V_W);
  // Truncate only once the coordinate is known to be inside the frame.
  assign addr     = in_range ? ADDR_W'(lin) : '0;
endmodule

// File: rtl/vga_fb_ctrl.sv
// Frame-buffer write controller: host pixel writes (1-cycle latency) and a
// whole-frame fill engine sharing one registered RAM write port.
module vga_fb_ctrl #(
  parameter int H_RES  = vga_pkg::H_RES,
  parameter int V_RES  = vga_pkg::V_RES,
  parameter int ADDR_W = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [10:0]       pix_x,
  input  logic [10:0]       pix_y,
  input  logic              pix_val,
  input  logic              fill_start,
  input  logic              fill_val,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_d,
  output logic [15:0]       drop_count
);
  import vga_pkg::*;

  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(H_RES * V_RES - 1);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              fill_val_q, fill_val_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_d_q, ram_d_d;
  logic              fill_done_q, fill_done_d;
  logic [15:0]       drop_q, drop_d;

  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] calc_addr;

  vga_addr_calc #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_calc (
    .x        (pix_x),
    .y        (pix_y),
    .in_range (in_range),
    .addr     (calc_addr)
  );

  assign pix_ready  = (state_q == ST_IDLE) && !fill_start;
  assign accept     = pix_valid && pix_ready;
  assign fill_busy  = (state_q == ST_FILL);
  assign fill_done  = fill_done_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_d      = ram_d_q;
  assign drop_count = drop_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fill_start)            state_d = ST_FILL;
      ST_FILL: if (cnt_q == FILL_LAST)    state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // The RAM port register is loaded one edge ahead, so every FILL cycle
  // presents ram_addr == cnt_q and the done pulse lands after the last write.
  always_comb begin
    cnt_d       = cnt_q;
    fill_val_d  = fill_val_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_d_d     = ram_d_q;
    fill_done_d = 1'b0;
    drop_d      = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          cnt_d      = '0;
          fill_val_d = fill_val;
          ram_we_d   = 1'b1;
          ram_addr_d = '0;
          ram_d_d    = fill_val;
        end else if (accept) begin
          if (in_range) begin
            ram_we_d   = 1'b1;
            ram_addr_d = calc_addr;
            ram_d_d    = pix_val;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
      end
      ST_FILL: begin
        if (cnt_q == FILL_LAST) begin
          fill_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + ADDR_W'(1);
          ram_we_d   = 1'b1;
          ram_addr_d = cnt_q + ADDR_W'(1);
          ram_d_d    = fill_val_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      fill_val_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_d_q     <= 1'b0;
      fill_done_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      fill_val_q  <= fill_val_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_d_q     <= ram_d_d;
      fill_done_q <= fill_done_d;
      drop_q      <= drop_d;
    end
  end
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Directed bench for vga_fb_ctrl on a reduced 80x48 frame so fill and
// drop-counter saturation both fit in a short run.
module tb_vga_fb_ctrl;
  localparam int H = 80;
  localparam int V = 48;
  localparam int AW = 19;
  localparam int DEPTH = H * V;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [10:0]   pix_x = '0;
  logic [10:0]   pix_y = '0;
  logic          pix_val = 1'b0;
  logic          fill_start = 1'b0;
  logic          fill_val = 1'b0;
  logic          fill_busy;
  logic          fill_done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic          ram_d;
  logic [15:0]   drop_count;

  int n_chk = 0;
  int n_fail = 0;

  vga_fb_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_val    (pix_val),
    .fill_start (fill_start),
    .fill_val   (fill_val),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_d      (ram_d),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic v);
    pix_valid = 1'b1;
    pix_x = 11'(x);
    pix_y = 11'(y);
    pix_val = v;
    step();
    pix_valid = 1'b0;
  endtask

  // Starts a fill and walks every write cycle; ends sampling the done cycle.
  task automatic run_fill(input logic v, input bit poke);
    fill_start = 1'b1;
    fill_val = v;
    #1 chk("ready_low_on_fill_start", 32'(pix_ready), 32'd0);
    step();
    fill_start = 1'b0;
    fill_val = ~v;
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_cycle", 32'({ram_we, ram_addr, ram_d, fill_busy, pix_ready, fill_done}),
          32'({1'b1, AW'(i), v, 1'b1, 1'b0, 1'b0}));
      if (poke && i == 100) begin
        fill_start = 1'b1;
        fill_val = ~v;
      end
      if (poke && i == 101) fill_start = 1'b0;
      step();
    end
    chk("fill_done_cycle", 32'({ram_we, ram_addr, fill_done, fill_busy, pix_ready}),
        32'({1'b0, AW'(DEPTH - 1), 1'b1, 1'b0, 1'b1}));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_d", 32'(ram_d), 32'd0);
    chk("rst_busy_done", 32'({fill_busy, fill_done}), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    reset_n = 1'b1;
    #1 chk("ready_after_reset", 32'(pix_ready), 32'd1);

    pix(0, 0, 1'b1);
    chk("pix_0_0", 32'({ram_we, ram_addr, ram_d}), 32'({1'b1, AW'(0), 1'b1}));
    step();
    chk("idle_hold", 32'({ram_we, ram_addr, ram_d}), 32'({1'b0, AW'(0), 1'b1}));

    pix(79, 47, 1'b0);
    chk("pix_last", 32'({ram_we, ram_addr, ram_d}), 32'({1'b1, AW'(3839), 1'b0}));
    pix(5, 2, 1'b1);
    chk("pix_5_2", 32'({ram_we, ram_addr, ram_d}), 32'({1'b1, AW'(165), 1'b1}));

    pix_valid = 1'b1; pix_x = 11'd1; pix_y = 11'd0; pix_val = 1'b1;
    step();
    chk("b2b_first", 32'({ram_we, ram_addr, ram_d}), 32'({1'b1, AW'(1), 1'b1}));
    pix_x = 11'd2; pix_val = 1'b0;
    step();
    chk("b2b_second", 32'({ram_we, ram_addr, ram_d}), 32'({1'b1, AW'(2), 1'b0}));
    pix_valid = 1'b0;
    step();
    chk("b2b_idle", 32'({ram_we, ram_addr}), 32'({1'b0, AW'(2)}));

    pix(80, 0, 1'b1);
    chk("drop_x_we", 32'({ram_we, ram_addr, ram_d}), 32'({1'b0, AW'(2), 1'b0}));
    chk("drop_x_cnt", 32'(drop_count), 32'd1);
    pix(0, 48, 1'b1);
    chk("drop_y_cnt", 32'({ram_we, drop_count}), 32'({1'b0, 16'd2}));
    pix(2047, 2047, 1'b1);
    chk("drop_max_cnt", 32'({ram_we, drop_count}), 32'({1'b0, 16'd3}));

    run_fill(1'b0, 1'b1);
    step();
    chk("fill_done_pulse_end", 32'({fill_done, ram_we, fill_busy}), 32'd0);

    pix_valid = 1'b1; pix_x = 11'd3; pix_y = 11'd1; pix_val = 1'b1;
    run_fill(1'b1, 1'b0);
    step();
    pix_valid = 1'b0;
    chk("pix_after_fill", 32'({ram_we, ram_addr, ram_d}), 32'({1'b1, AW'(83), 1'b1}));
    chk("drop_kept", 32'(drop_count), 32'd3);

    fill_start = 1'b1; fill_val = 1'b1;
    step();
    fill_start = 1'b0;
    repeat (1000) step();
    chk("abort_at_1000", 32'({ram_we, ram_addr, fill_busy}), 32'({1'b1, AW'(1000), 1'b1}));
    reset_n = 1'b0;
    #1 chk("abort_async", 32'({ram_we, ram_addr, fill_busy, fill_done}), 32'd0);
    chk("abort_drop", 32'(drop_count), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    #1 chk("abort_ready", 32'(pix_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_quiet", 32'({ram_we, fill_done, fill_busy}), 32'd0);
    end

    pix_valid = 1'b1; pix_x = 11'd100; pix_y = 11'd0; pix_val = 1'b1;
    repeat (65534) step();
    chk("drop_65534", 32'(drop_count), 32'd65534);
    step();
    chk("drop_65535", 32'(drop_count), 32'd65535);
    repeat (4465) step();
    chk("drop_saturated", 32'({ram_we, drop_count}), 32'({1'b0, 16'hFFFF}));
    pix_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_fb_ctrl.md
VGA_FB_CTRL -- requirements
Module: vga_fb_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 800, visible pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, visible lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 19, frame-buffer write-address width.
REQ-004 SHALL have port clk, input, 1, the system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pix_valid, input, 1, host pixel-write request.
REQ-007 SHALL have port pix_ready, output, 1, the host write is accepted when pix_valid and pix_ready are both high.
REQ-008 SHALL have port pix_x, input, 11, host pixel column.
REQ-009 SHALL have port pix_y, input, 11, host pixel row.
REQ-010 SHALL have port pix_val, input, 1, host pixel bit.
REQ-011 SHALL have port fill_start, input, 1, single-cycle request to fill the whole frame buffer.
REQ-012 SHALL have port fill_val, input, 1, fill bit, sampled with fill_start.
REQ-013 SHALL have port fill_busy, output, 1, high while a fill is in progress.
REQ-014 SHALL have port fill_done, output, 1, single-cycle pulse when a fill completes.
REQ-015 SHALL have port ram_we, output, 1, RAM write enable.
REQ-016 SHALL have port ram_addr, output, ADDR_W, RAM write address.
REQ-017 SHALL have port ram_d, output, 1, RAM write data.
REQ-018 SHALL have port drop_count, output, 16, count of dropped out-of-range host writes.

Function
REQ-019 SHALL use a two-state FSM: IDLE and FILL.
REQ-020 SHALL drive pix_ready = (state==IDLE) && !fill_start, as a combinational output.
REQ-021 In IDLE, fill_start SHALL move the FSM to FILL, latch fill_val and clear the fill counter to 0; host writes in that same cycle are not accepted.
REQ-022 In FILL, SHALL write every cycle: ram_we=1, ram_addr=counter, ram_d=latched fill_val.
REQ-023 In FILL, the counter SHALL increment from 0 through H_RES*V_RES-1 (383999 at defaults), for exactly H_RES*V_RES writes.
REQ-024 On the cycle after the last fill write, SHALL pulse fill_done=1 for one cycle and return to IDLE.
REQ-025 fill_start asserted during FILL SHALL be ignored and SHALL NOT restart the fill.
REQ-026 fill_busy SHALL be high in FILL, starting the cycle after fill_start, and low otherwise.
REQ-027 An accepted in-range host write (pix_x<H_RES and pix_y<V_RES) SHALL produce ram_we=1, ram_addr=pix_y*H_RES+pix_x and ram_d=pix_val one cycle after acceptance (latency 1, registered).
REQ-028 Address arithmetic SHALL use at least 21-bit intermediates, truncated to ADDR_W only after the range check.
REQ-029 An accepted out-of-range host write SHALL NOT assert ram_we and SHALL increment drop_count, saturating at 16'hFFFF.
REQ-030 Back-to-back accepted host writes SHALL sustain one RAM write per cycle.
REQ-031 When no write is issued, ram_we SHALL be 0 and ram_addr/ram_d SHALL hold their previous values.
REQ-032 The block SHALL never drive a RAM write address >= H_RES*V_RES.

Reset
REQ-033 reset_n low SHALL asynchronously set: state=IDLE, counter=0, ram_we=0, ram_addr=0, ram_d=0, fill_busy=0, fill_done=0, drop_count=0.
REQ-034 Reset asserted mid-fill SHALL abort the fill with no fill_done pulse; the frame-buffer contents are then undefined.
REQ-035 pix_ready SHALL be 1 in the first cycle after reset release unless fill_start is high.

Structure
REQ-036 The shared package vga_pkg SHALL hold H_RES, V_RES, FB_DEPTH (H_RES*V_RES), ADDR_W and the FSM state enum.
REQ-037 Coordinate-to-address translation with the range check SHALL be a sub-module, vga_addr_calc, which is combinational and reused by the read side.

Verification
REQ-038 Bench SHALL cover: reset, then pix (x=0,y=0,val=1) -> next cycle ram_we=1, ram_addr=0, ram_d=1.
REQ-039 Bench SHALL cover: pix (x=799,y=479) -> ram_addr=383999; then pix (x=800,y=0) -> no ram_we, drop_count=1.
REQ-040 Bench SHALL cover: fill_start with fill_val=0 -> 384000 consecutive writes at addresses 0..383999, then one fill_done pulse, with pix_ready low throughout.
REQ-041 Bench SHALL cover: fill_start and pix_valid in the same IDLE cycle -> fill runs and the pixel write is accepted only after fill_done.
REQ-042 Bench SHALL cover: reset_n pulsed low at fill address 1000 -> ram_we=0 immediately, no fill_done, pix_ready=1 after release.
REQ-043 Bench SHALL cover: 70000 out-of-range writes -> drop_count saturates at 65535.
